// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerance block family:
// common bus widths and the recovery sequencer state encoding.
package ft_pkg;

  localparam int unsigned FT_ADDR_WIDTH = 5;
  localparam int unsigned FT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COPY,
    FLUSH,
    PC,
    DONE
  } rf_restore_state_e;

endpackage

// File: rtl/rf_restore_if.sv
// Bundle of the control, sgpr/spc and register-file write signals of the
// recovery sequencer. The slave modport is the sequencer; master is its environment.
interface rf_restore_if
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FT_DATA_WIDTH
);

  logic                  halt_i;
  logic                  idle_a_i;
  logic                  idle_b_i;
  logic [ADDR_WIDTH-1:0] raddr_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic [DATA_WIDTH-1:0] spc_i;
  logic                  we_a_o;
  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  pc_valid_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  timeout_o;

  modport slave (
    input  halt_i, idle_a_i, idle_b_i, rdata_i, spc_i,
    output raddr_o, we_a_o, we_b_o, waddr_o, wdata_o,
           pc_valid_o, pc_o, busy_o, done_o, timeout_o
  );

  modport master (
    output halt_i, idle_a_i, idle_b_i, rdata_i, spc_i,
    input  raddr_o, we_a_o, we_b_o, waddr_o, wdata_o,
           pc_valid_o, pc_o, busy_o, done_o, timeout_o
  );

endinterface

// File: rtl/rf_restore.sv
// Recovery sequencer: after a halt rising edge, waits for both lockstep cores
// to drain, copies the safe GPR image into both register files, then issues
// the safe PC as restart address and pulses done.
module rf_restore
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = FT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = FT_DATA_WIDTH,
  parameter bit          SKIP_ZERO     = 1'b1,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_restore_if.slave bus
);

  localparam int unsigned DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DCW-1:0]        DRAIN_LIMIT = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST  = SKIP_ZERO ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = '1;

  rf_restore_state_e     state_q, state_d;
  logic                  halt_q;
  logic [DCW-1:0]        dcnt_q, dcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  timeout_q, timeout_d;
  logic                  start;

  assign start = bus.halt_i & ~halt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update; the write stage trails the read by one cycle.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRAIN;
          dcnt_d    = '0;
          timeout_d = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.idle_a_i && bus.idle_b_i) begin
          state_d = COPY;
          addr_d  = ADDR_FIRST;
        end else if (dcnt_q == DRAIN_LIMIT) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      COPY: begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = bus.rdata_i;
        if (addr_q == ADDR_LAST) begin
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = PC;
        pc_d    = bus.spc_i;
      end
      PC: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Halt edge register, counters, write stage, restart PC and timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q    <= 1'b0;
      dcnt_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      halt_q    <= bus.halt_i;
      dcnt_q    <= dcnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.raddr_o    = addr_q;
  assign bus.we_a_o     = we_q;
  assign bus.we_b_o     = we_q;
  assign bus.waddr_o    = waddr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.pc_valid_o = (state_q == PC);
  assign bus.pc_o       = pc_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = (state_q == DONE);
  assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_rf_restore.sv
// Bench for rf_restore: two instances (SKIP_ZERO=1 and SKIP_ZERO=0) share
// stimulus; a table of recovery scenarios plus a mid-copy reset sequence.
module tb_rf_restore;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        idle_a = 1'b1;
  logic        idle_b = 1'b1;
  logic [31:0] spc = '0;
  logic [31:0] mem [32];
  bit          sel = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rf_restore_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if0 ();
  rf_restore_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if1 ();

  assign if0.halt_i   = halt;
  assign if0.idle_a_i = idle_a;
  assign if0.idle_b_i = idle_b;
  assign if0.spc_i    = spc;
  assign if0.rdata_i  = mem[if0.raddr_o];
  assign if1.halt_i   = halt;
  assign if1.idle_a_i = idle_a;
  assign if1.idle_b_i = idle_b;
  assign if1.spc_i    = spc;
  assign if1.rdata_i  = mem[if1.raddr_o];

  rf_restore #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b1), .DRAIN_TIMEOUT(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  rf_restore #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b0), .DRAIN_TIMEOUT(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  logic        s_we_a, s_we_b, s_busy, s_done, s_pcv, s_to;
  logic [4:0]  s_raddr, s_waddr;
  logic [31:0] s_wdata, s_pc;

  always_comb begin
    s_we_a  = sel ? if1.we_a_o     : if0.we_a_o;
    s_we_b  = sel ? if1.we_b_o     : if0.we_b_o;
    s_busy  = sel ? if1.busy_o     : if0.busy_o;
    s_done  = sel ? if1.done_o     : if0.done_o;
    s_pcv   = sel ? if1.pc_valid_o : if0.pc_valid_o;
    s_to    = sel ? if1.timeout_o  : if0.timeout_o;
    s_raddr = sel ? if1.raddr_o    : if0.raddr_o;
    s_waddr = sel ? if1.waddr_o    : if0.waddr_o;
    s_wdata = sel ? if1.wdata_o    : if0.wdata_o;
    s_pc    = sel ? if1.pc_o       : if0.pc_o;
  end

  typedef struct {
    bit          sel;        // 0: SKIP_ZERO=1 instance, 1: SKIP_ZERO=0 instance
    int          rise;       // drain cycle (1-based) in which idle_b is first seen; 0 = never
    bit          glitch;     // drop and re-raise halt during COPY
    logic [31:0] spc;
    int          exp_writes;
    int          exp_first;  // -1 when no write expected
    int          exp_done;   // edge index (trigger edge = 1) where done_o is seen; 0 = none
    int          exp_end;    // edge index where busy_o is first seen low
    bit          exp_to;
    int          exp_pcv;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         writes = 0;
    int         first = -1;
    int         done_n = 0;
    int         done_cnt = 0;
    int         pcv = 0;
    int         end_n = 0;
    int         restart = 0;
    logic [4:0] expaddr;
    sel    = v.sel;
    spc    = v.spc;
    idle_a = 1'b1;
    idle_b = (v.rise == 1);
    halt   = 1'b0;
    expaddr = v.exp_first[4:0];
    repeat (2) @(posedge clk);
    #1;
    halt = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk("busy_after_trigger", 32'(s_busy), 32'd1);
        chk("timeout_cleared", 32'(s_to), 32'd0);
      end
      if (s_we_a || s_we_b) begin
        chk("we_pair", 32'(s_we_b), 32'(s_we_a));
        if (first < 0) first = int'(s_waddr);
        chk("waddr_seq", 32'(s_waddr), 32'(expaddr));
        chk("wdata", s_wdata, mem[s_waddr]);
        expaddr++;
        writes++;
      end
      if (s_done) begin
        if (done_cnt == 0) done_n = n;
        done_cnt++;
      end
      if (s_pcv) begin
        pcv++;
        chk("pc_o", s_pc, v.spc);
      end
      if (!s_busy) begin
        end_n = n;
        break;
      end
      if (v.glitch && n == 10) halt = 1'b0;
      if (v.glitch && n == 12) halt = 1'b1;
      if (v.rise > 1 && n >= v.rise) idle_b = 1'b1;
    end
    chk("write_count", writes, v.exp_writes);
    chk("first_addr", first, v.exp_first);
    chk("done_cycle", done_n, v.exp_done);
    chk("done_count", done_cnt, (v.exp_done != 0) ? 1 : 0);
    chk("pc_valid_count", pcv, v.exp_pcv);
    chk("end_cycle", end_n, v.exp_end);
    chk("timeout_flag", 32'(s_to), 32'(v.exp_to));
    // halt still high: no retrigger; spc changes must not reach pc_o
    spc = ~v.spc;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (s_busy || s_we_a || s_we_b || s_done || s_pcv) restart++;
    end
    chk("no_retrigger", restart, 0);
    if (v.exp_pcv != 0) chk("pc_hold", s_pc, v.spc);
    halt = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    vecs[0] = '{sel: 1'b0, rise: 1,  glitch: 1'b0, spc: 32'h0000_1A40, exp_writes: 31, exp_first: 1,
                exp_done: 35, exp_end: 36, exp_to: 1'b0, exp_pcv: 1};
    vecs[1] = '{sel: 1'b0, rise: 10, glitch: 1'b0, spc: 32'h8000_0100, exp_writes: 31, exp_first: 1,
                exp_done: 44, exp_end: 45, exp_to: 1'b0, exp_pcv: 1};
    vecs[2] = '{sel: 1'b0, rise: 0,  glitch: 1'b0, spc: 32'h1234_5678, exp_writes: 0,  exp_first: -1,
                exp_done: 0,  exp_end: 65, exp_to: 1'b1, exp_pcv: 0};
    vecs[3] = '{sel: 1'b1, rise: 1,  glitch: 1'b0, spc: 32'hDEAD_BEE0, exp_writes: 32, exp_first: 0,
                exp_done: 36, exp_end: 37, exp_to: 1'b0, exp_pcv: 1};
    vecs[4] = '{sel: 1'b0, rise: 1,  glitch: 1'b1, spc: 32'h0040_0000, exp_writes: 31, exp_first: 1,
                exp_done: 35, exp_end: 36, exp_to: 1'b0, exp_pcv: 1};

    // reset state
    #12;
    chk("reset_ctl", 32'({s_we_a, s_we_b, s_busy, s_done, s_pcv, s_to}), 32'd0);
    chk("reset_raddr", 32'(s_raddr), 32'd0);
    chk("reset_pc", s_pc, 32'd0);
    #11;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // asynchronous reset in the middle of COPY
    sel    = 1'b0;
    spc    = 32'h0000_2000;
    idle_a = 1'b1;
    idle_b = 1'b1;
    halt   = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (s_busy && s_raddr == 5'd12) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_addr12", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'({s_we_a, s_we_b, s_busy, s_done, s_pcv, s_to}), 32'd0);
    chk("midrst_raddr", 32'(s_raddr), 32'd0);
    chk("midrst_waddr", 32'(s_waddr), 32'd0);
    chk("midrst_wdata", s_wdata, 32'd0);
    chk("midrst_pc", s_pc, 32'd0);
    halt = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(s_busy), 32'd0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
